// File: rtl/very_simple_cpu.sv
// very_simple_cpu: multi-cycle 32-bit memory-to-memory core for the
// VerySimpleCPU ISA. All operands live in an external single-port RAM
// (1-cycle read latency, write on posedge). Every output comes straight
// from a register.
// Build option: define VSCPU_MUL_EN to include the multiplier. Without it,
// opcode 4 retires as a NOP with the normal 6-cycle latency.
module very_simple_cpu #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_fromRAM,
  output logic              wrEn,
  output logic [ADDR_W-1:0] addr_toRAM,
  output logic [31:0]       data_toRAM
);

  typedef enum logic [2:0] {
    FETCH, LD_IW, RD_A, RD_B, LD_B, EXEC, IND, IND_WB
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       iw, r1, r2;

  logic [2:0]        op;
  logic              imm;
  logic [13:0]       fA, fB;
  logic [31:0]       op2, result;
  logic              doWr;
  logic [ADDR_W-1:0] wrAddr, pcInc, nextPc;

  assign op  = iw[31:29];
  assign imm = iw[28];
  assign fA  = iw[27:14];
  assign fB  = iw[13:0];

  // Second operand arrives from RAM in LD_B. CPIi always needs the real *B.
  always_comb begin
    op2 = data_fromRAM;
    if (imm && op != 3'd6) op2 = {18'b0, fB};
  end

  // ALU result and write decision, sampled on the LD_B -> EXEC edge.
  always_comb begin
    result = 32'b0;
    doWr   = 1'b0;
    case (op)
      3'd0: begin result = r1 + op2;    doWr = 1'b1; end
      3'd1: begin result = ~(r1 & op2); doWr = 1'b1; end
      3'd2: begin
        result = (op2 < 32'd32) ? (r1 >> op2) : (r1 << (op2 - 32'd32));
        doWr   = 1'b1;
      end
      3'd3: begin result = {31'b0, (r1 < op2)}; doWr = 1'b1; end
`ifdef VSCPU_MUL_EN
      3'd4: begin result = r1 * op2;    doWr = 1'b1; end
`else
      3'd4: begin result = 32'b0;       doWr = 1'b0; end
`endif
      3'd5: begin result = op2;         doWr = 1'b1; end
      3'd6: begin result = op2;         doWr = imm;  end  // CPIi only; CPI writes later
      default: begin result = 32'b0;    doWr = 1'b0; end
    endcase
  end

  // Write target is *A, except CPIi which stores through the pointer in *A.
  assign wrAddr = (op == 3'd6 && imm) ? r1[ADDR_W-1:0] : fA[ADDR_W-1:0];

  // Branch target resolution, evaluated in EXEC from latched operands.
  always_comb begin
    pcInc  = pc + 1'b1;
    nextPc = pcInc;
    if (op == 3'd7) begin
      if (imm)             nextPc = r1[ADDR_W-1:0] + fB[ADDR_W-1:0];
      else if (r2 == 32'b0) nextPc = r1[ADDR_W-1:0];
    end
  end

  // Main sequencer: one state per cycle, outputs registered on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= '0;
      iw         <= '0;
      r1         <= '0;
      r2         <= '0;
      wrEn       <= 1'b0;
      addr_toRAM <= '0;
      data_toRAM <= '0;
    end else begin
      case (state)
        FETCH: state <= LD_IW;
        LD_IW: begin
          iw         <= data_fromRAM;
          addr_toRAM <= data_fromRAM[14 +: ADDR_W];
          state      <= RD_A;
        end
        RD_A: begin
          addr_toRAM <= fB[ADDR_W-1:0];
          state      <= RD_B;
        end
        RD_B: begin
          r1    <= data_fromRAM;
          state <= LD_B;
        end
        LD_B: begin
          r2    <= op2;
          state <= EXEC;
          if (op == 3'd6 && !imm) begin
            addr_toRAM <= op2[ADDR_W-1:0];   // CPI: fetch *(*B) next
          end else if (doWr) begin
            wrEn       <= 1'b1;
            addr_toRAM <= wrAddr;
            data_toRAM <= result;
          end
        end
        EXEC: begin
          wrEn       <= 1'b0;
          data_toRAM <= '0;
          if (op == 3'd6 && !imm) begin
            state <= IND;
          end else begin
            pc         <= nextPc;
            addr_toRAM <= nextPc;
            state      <= FETCH;
          end
        end
        IND: begin
          wrEn       <= 1'b1;
          addr_toRAM <= fA[ADDR_W-1:0];
          data_toRAM <= data_fromRAM;
          state      <= IND_WB;
        end
        IND_WB: begin
          wrEn       <= 1'b0;
          data_toRAM <= '0;
          pc         <= pcInc;
          addr_toRAM <= pcInc;
          state      <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_very_simple_cpu.sv
// Scoreboard bench for very_simple_cpu: directed programs, expected RAM
// writes (address, data, cycle since reset release) queued up front and
// checked by a monitor whenever the core drives wrEn.
module tb_very_simple_cpu;

  logic        clk, rst;
  logic [31:0] rdData;
  logic        wrEn;
  logic [13:0] addr;
  logic [31:0] wdata;

  logic [31:0] mem [0:16383];
  logic        clr, ld;
  logic [13:0] ldA;
  logic [31:0] ldD;
  int          cyc;

  typedef struct {
    int          a;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t expQ[$];

  int checks = 0;
  int errs   = 0;

  localparam logic [31:0] LOOP = 32'hF032_0000;  // BZJi A=200 (zero) | self address

  very_simple_cpu #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .data_fromRAM(rdData),
    .wrEn(wrEn), .addr_toRAM(addr), .data_toRAM(wdata)
  );

  always #5 clk = ~clk;

  // Companion RAM: 1-cycle read, write on posedge, plus bench load/clear.
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 16384; i++) mem[i] <= 32'b0;
    else if (ld) mem[ldA] <= ldD;
    else if (rst && wrEn) mem[addr] <= wdata;
    rdData <= mem[addr];
  end

  // Rising edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if (wrEn) begin
          if (expQ.size() == 0) begin
            errs++;
            $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", addr, wdata, cyc);
          end else begin
            e = expQ.pop_front();
            if (addr != e.a[13:0] || wdata != e.d || cyc != e.c) begin
              errs++;
              $display("FAIL write got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                       addr, wdata, cyc, e.a, e.d, e.c);
            end
          end
        end else if (wdata != 32'b0) begin
          errs++;
          $display("FAIL idle_data got %h want 0 cyc=%0d", wdata, cyc);
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic pushExp(input int a, input logic [31:0] d, input int c);
    exp_t e;
    e.a = a; e.d = d; e.c = c;
    expQ.push_back(e);
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    ldA = 14'(a); ldD = d; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Hold reset, wipe RAM; caller then pokes the program.
  task automatic startTest();
    rst = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic release_();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic runCycles(input int n, input string name);
    repeat (n) @(posedge clk);
    @(negedge clk); #1;
    check({name, "_pending"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; clr = 1'b0; ld = 1'b0; ldA = '0; ldD = '0;
    fork monitor(); join_none

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_wrEn", 32'(wrEn), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", wdata, 32'd0);

    // ADD, ADDi, SRL (left-shift wrap), NAND, LTi false, CPi
    startTest();
    poke(0, 32'h0019_0065); poke(1, 32'h1019_0003); poke(2, 32'h4019_0066);
    poke(3, 32'h2019_0067); poke(4, 32'h7019_002D); poke(5, 32'hB019_C03F);
    poke(6, LOOP | 32'd6);
    poke(100, 32'd5); poke(101, 32'd10); poke(102, 32'd61); poke(103, 32'hFFFF_FFFF);
    pushExp(100, 32'd15, 5);
    pushExp(100, 32'd18, 11);
    pushExp(100, 32'h4000_0000, 17);
    pushExp(100, 32'hBFFF_FFFF, 23);
    pushExp(100, 32'd0, 29);
    pushExp(103, 32'd63, 35);
    release_();
    runCycles(50, "alu");

    // BZJ not taken, BZJ taken, BZJi; landing points leave write markers
    startTest();
    poke(0, 32'hE019_0065); poke(1, 32'h1019_0003); poke(2, 32'hE019_0066);
    poke(10, 32'hF032_0019); poke(25, 32'h1019_0001); poke(26, LOOP | 32'd26);
    poke(100, 32'd7); poke(101, 32'd10); poke(102, 32'd0);
    pushExp(100, 32'd10, 11);
    pushExp(100, 32'd11, 29);
    release_();
    runCycles(45, "branch");

    // MUL, LTi true, CPI (8 cycles), CPIi
    startTest();
    poke(0, 32'h8019_4064); poke(1, 32'h7019_002D); poke(2, 32'hC01A_0069);
    poke(3, 32'hD01A_006A); poke(4, LOOP | 32'd4);
    poke(100, 32'd5); poke(101, 32'd3); poke(105, 32'd40); poke(40, 32'h4B);
    poke(106, 32'h0000_CAFE);
`ifdef VSCPU_MUL_EN
    pushExp(101, 32'd15, 5);
`endif
    pushExp(100, 32'd1, 11);
    pushExp(104, 32'h4B, 19);
    pushExp(75, 32'h0000_CAFE, 25);
    release_();
    runCycles(45, "mul_ind");
    check("mul_mem101", mem[101],
`ifdef VSCPU_MUL_EN
          32'd15
`else
          32'd3
`endif
         );

    // Reset during EXEC of an ADD aborts the write, then refetch from 0
    startTest();
    poke(0, 32'h0019_0065); poke(1, LOOP | 32'd1);
    poke(100, 32'd5); poke(101, 32'd10);
    release_();
    repeat (5) @(posedge clk); #1;
    check("pre_abort_wrEn", 32'(wrEn), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_wrEn", 32'(wrEn), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_data", wdata, 32'd0);
    repeat (3) @(posedge clk); #1;
    check("abort_mem100", mem[100], 32'd5);
    pushExp(100, 32'd15, 5);
    release_();
    runCycles(20, "refetch");
    check("refetch_mem100", mem[100], 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
